alu_seq_param: RTL and testbench

- Parametrised, registered successor to the team's combinational 16-bit ALU.
- Width is generic. Adds SRL, SRA, XOR and an optional iterative shift-add multiplier, plus a signed-overflow flag.
- Valid/ready handshakes sit on both input and output, so the block can live between pipeline stages of the datapath.
- One operation is in flight at a time; the result is held in an output register until consumed.

---
 rtl/alu_seq_param.sv | 219 +++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered, parametrised ALU with valid/ready on both sides.
// Operations: ADD, SUB, AND, OR, SLL, SRL, SRA, XOR and an optional MUL.
// MUL is an iterative shift-add multiplier.
// Optional feature macro: ALU_MUL_EN.
//   - Defined: the multiplier, the MUL_BUSY state and the iteration counter
//     are built in.
//   - Undefined: opcode 8 falls through to the default-opcode behaviour.
// One operation is in flight at a time. The result register holds its value
// until the downstream stage takes it.
module alu_seq_param #(
    parameter  int WIDTH = 16,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SW-1:0]    shiftValue,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             signFlag,
    output logic             overflowFlag
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

    // Output registers
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             zero_r;
    logic             sign_r;
    logic             ovf_r;
    logic             out_valid_r;

    // Single-cycle datapath
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;

    // Handshake
    logic             in_ready_s;
    logic             accept_s;
    logic             load_s;

`ifdef ALU_MUL_EN
    localparam logic [3:0]  OP_MUL   = 4'd8;
    localparam logic [SW:0] CNT_LAST = (SW+1)'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [SW:0]        cnt_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH:0]     psum_s;
    logic               mul_start_s;
    logic               mul_last_s;
`endif

    // Accept and load qualifiers; a new request waits until the previous result leaves or is leaving
    always_comb begin
`ifdef ALU_MUL_EN
        in_ready_s  = (state_r == IDLE) && (!out_valid_r || outReady);
        accept_s    = inValid && in_ready_s;
        mul_start_s = accept_s && (opcode == OP_MUL);
        mul_last_s  = (state_r == MUL_BUSY) && (cnt_r == CNT_LAST);
        load_s      = accept_s && !mul_start_s;
`else
        in_ready_s  = !out_valid_r || outReady;
        accept_s    = inValid && in_ready_s;
        load_s      = accept_s;
`endif
    end

    // Single-cycle operation result, carry/borrow and signed overflow
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        add_s   = {1'b0, input1} + {1'b0, input2};
        sub_s   = {1'b0, input1} - {1'b0, input2};
        case (opcode)
            OP_ADD: begin
                res_s   = add_s[WIDTH-1:0];
                carry_s = add_s[WIDTH];
                ovf_s   = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                          (add_s[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                res_s   = sub_s[WIDTH-1:0];
                carry_s = sub_s[WIDTH];
                ovf_s   = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                          (sub_s[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_AND:  res_s = input1 & input2;
            OP_OR:   res_s = input1 | input2;
            OP_XOR:  res_s = input1 ^ input2;
            OP_SLL:  res_s = input1 << shiftValue;
            OP_SRL:  res_s = input1 >> shiftValue;
            OP_SRA:  res_s = $signed(input1) >>> shiftValue;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_MUL_EN
    // One shift-add step: conditionally add the multiplicand to the upper half, then shift right
    always_comb begin
        psum_s      = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                      (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        prod_next_s = {psum_s, prod_r[WIDTH-1:1]};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: enter MUL_BUSY on a MUL accept, leave after the last step
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (mul_start_s) begin
                    state_s = MUL_BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL_BUSY: begin
                if (mul_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = MUL_BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Multiplier operands, partial product and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {(SW+1){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
        end else if (mul_start_s) begin
            cnt_r   <= {(SW+1){1'b0}};
            mcand_r <= input1;
            prod_r  <= {{WIDTH{1'b0}}, input2};
        end else if (state_r == MUL_BUSY) begin
            cnt_r   <= cnt_r + {{SW{1'b0}}, 1'b1};
            prod_r  <= prod_next_s;
        end
    end
`endif

    // Output register: load on accept or on MUL completion, drop valid on drain, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            result_r    <= res_s;
            carry_r     <= carry_s;
            zero_r      <= (res_s == {WIDTH{1'b0}});
            sign_r      <= res_s[WIDTH-1];
            ovf_r       <= ovf_s;
            out_valid_r <= 1'b1;
`ifdef ALU_MUL_EN
        end else if (mul_last_s) begin
            result_r    <= prod_next_s[WIDTH-1:0];
            carry_r     <= |prod_next_s[2*WIDTH-1:WIDTH];
            zero_r      <= (prod_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            sign_r      <= prod_next_s[WIDTH-1];
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b1;
`endif
        end else if (out_valid_r && outReady) begin
            out_valid_r <= 1'b0;
        end
    end

    assign inReady      = in_ready_s;
    assign outValid     = out_valid_r;
    assign result       = result_r;
    assign carryFlag    = carry_r;
    assign zeroFlag     = zero_r;
    assign signFlag     = sign_r;
    assign overflowFlag = ovf_r;

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param (WIDTH=16).
// The driver pushes the expected response when a request is accepted.
// The monitor pops and compares every result the DUT hands over.
module tb_alu_seq_param;

    localparam int W  = 16;
    localparam int SW = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         s;
        logic         v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid;
    logic          inReady;
    logic [3:0]    opcode;
    logic [W-1:0]  input1;
    logic [W-1:0]  input2;
    logic [SW-1:0] shiftValue;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  result;
    logic          carryFlag;
    logic          zeroFlag;
    logic          signFlag;
    logic          overflowFlag;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
        .outValid(outValid), .outReady(outReady), .result(result),
        .carryFlag(carryFlag), .zeroFlag(zeroFlag), .signFlag(signFlag),
        .overflowFlag(overflowFlag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handed-over result is compared against the oldest expectation
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("scoreboard", {43'd0, result, carryFlag, zeroFlag, signFlag, overflowFlag},
                      {43'd0, e});
            end
        end
    end

    // Issue one request, wait (bounded) for inReady, record the expectation at the accepting edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SW-1:0] sh, input logic push, input exp_t e);
        bit ok;
        ok         = 1'b0;
        inValid    = 1'b1;
        opcode     = op;
        input1     = a;
        input2     = b;
        shiftValue = sh;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("inready_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            if (push) sb.push_back(e);
        end
        #1;
        inValid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic s,
                                input logic v);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.z   = (r == 16'h0000);
        e.s   = s;
        e.v   = v;
        return e;
    endfunction

    int busy_cnt;
    int ov_seen;

    initial begin
        rst        = 1'b1;
        inValid    = 1'b0;
        opcode     = 4'd0;
        input1     = 16'h0000;
        input2     = 16'h0000;
        shiftValue = 4'd0;
        outReady   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outvalid", {63'd0, outValid}, 64'd0);
        check("reset_inready", {63'd0, inReady}, 64'd1);
        check("reset_outputs", {44'd0, result, carryFlag, zeroFlag, signFlag, overflowFlag}, 64'd0);
        @(posedge clk);
        #1;

        // Arithmetic, logic and shift vectors
        issue(4'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b0));
        issue(4'd1, 16'h8000, 16'h0001, 4'd0, 1'b1, mk(16'h7FFF, 1'b0, 1'b0, 1'b1));
        issue(4'd1, 16'h0003, 16'h0005, 4'd0, 1'b1, mk(16'hFFFE, 1'b1, 1'b1, 1'b0));
        issue(4'd6, 16'h8010, 16'h1234, 4'd4, 1'b1, mk(16'hF801, 1'b0, 1'b1, 1'b0));
        issue(4'd5, 16'h8010, 16'h1234, 4'd4, 1'b1, mk(16'h0801, 1'b0, 1'b0, 1'b0));
        issue(4'd4, 16'h0001, 16'hFFFF, 4'd15, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        issue(4'd2, 16'hF0F0, 16'h3C3C, 4'd0, 1'b1, mk(16'h3030, 1'b0, 1'b0, 1'b0));
        issue(4'd3, 16'hF0F0, 16'h3C3C, 4'd0, 1'b1, mk(16'hFCFC, 1'b0, 1'b1, 1'b0));
        issue(4'd7, 16'hF0F0, 16'h3C3C, 4'd0, 1'b1, mk(16'hCCCC, 1'b0, 1'b1, 1'b0));
        issue(4'd0, 16'h7FFF, 16'h0001, 4'd0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b1));
        issue(4'd15, 16'h1234, 16'h5678, 4'd3, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b0));

        // Hold: stalled result stays put and blocks new requests
        @(posedge clk);
        #1 outReady = 1'b0;
        issue(4'd0, 16'h1234, 16'h1111, 4'd0, 1'b1, mk(16'h2345, 1'b0, 1'b0, 1'b0));
        inValid = 1'b1;
        opcode  = 4'd7;
        input1  = 16'h00FF;
        input2  = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_inready", {63'd0, inReady}, 64'd0);
            check("hold_result", {48'd0, result}, {48'd0, 16'h2345});
        end
        @(posedge clk);
        #1 outReady = 1'b1;
        @(negedge clk);
        check("release_inready", {63'd0, inReady}, 64'd1);
        @(posedge clk);
        sb.push_back(mk(16'h0FF0, 1'b0, 1'b0, 1'b0));
        #1 inValid = 1'b0;
        @(negedge clk);
        check("b2b_outvalid", {63'd0, outValid}, 64'd1);
        check("b2b_result", {48'd0, result}, {48'd0, 16'h0FF0});
        @(posedge clk);
        #1;

`ifdef ALU_MUL_EN
        // Multiplier: busy for WIDTH cycles, then result and high-half flag
        issue(4'd8, 16'h0100, 16'h0101, 4'd0, 1'b1, mk(16'h0100, 1'b1, 1'b0, 1'b0));
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inReady) break;
            busy_cnt++;
        end
        check("mul_busy_cycles", 64'(busy_cnt), 64'd16);
        @(posedge clk);
        #1;
        issue(4'd8, 16'h0003, 16'h0005, 4'd0, 1'b1, mk(16'h000F, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inReady) break;
        end
        @(posedge clk);
        #1;
        // Reset in the middle of a multiply aborts it
        issue(4'd8, 16'h00FF, 16'h00FF, 4'd0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0));
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {43'd0, outValid, result, carryFlag, zeroFlag, signFlag, overflowFlag},
              64'd0);
        check("abort_inready", {63'd0, inReady}, 64'd1);
        ov_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (outValid) ov_seen++;
        end
        check("abort_no_pulse", 64'(ov_seen), 64'd0);
`else
        // Without the multiplier opcode 8 is a default opcode
        issue(4'd8, 16'h0100, 16'h0101, 4'd0, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        check("op8_outvalid", {63'd0, outValid}, 64'd1);
        check("op8_zero", {63'd0, zeroFlag}, 64'd1);
        @(posedge clk);
        #1;
`endif

        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
